// File: rtl/unsigned_mul_8x8_seq_ctrl_pkg.sv
// Shared types and sizes for the sequential 8x8 unsigned multiplier.
// Operand, product and row-pair widths live here so every file agrees.
package unsigned_mul_8x8_seq_ctrl_pkg;

    localparam int ROWS  = 4;
    localparam int OP_W  = 8;
    localparam int P_W   = 16;
    localparam int ROW_W = OP_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/unsigned_mul_8x8_row_pair.sv
// Combinational row-pair generator: the sum of two adjacent partial-product
// rows, selected by a pair of multiplicand bits.
module unsigned_mul_8x8_row_pair
    import unsigned_mul_8x8_seq_ctrl_pkg::*;
(
    input  logic [1:0]       x_bits,
    input  logic [OP_W-1:0]  y,
    output logic [ROW_W-1:0] row
);

    logic [ROW_W-1:0] row_lo;
    logic [ROW_W-1:0] row_hi;

    always_comb begin
        row_lo = x_bits[0] ? {2'b00, y}       : '0;
        row_hi = x_bits[1] ? {1'b0, y, 1'b0}  : '0;
        // Largest sum is 255 + 510 = 765, so 10 bits hold it without loss.
        row    = row_lo + row_hi;
    end

endmodule

// File: rtl/unsigned_mul_8x8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: accepts an operand pair, accumulates
// two partial-product rows per cycle for four cycles, then holds the product.
module unsigned_mul_8x8_seq_ctrl
    import unsigned_mul_8x8_seq_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  x,
    input  logic [OP_W-1:0]  y,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P_W-1:0]   p,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_e           state_q, state_d;
    logic [1:0]       k_q, k_d;
    logic [P_W-1:0]   acc_q, acc_d;
    logic [OP_W-1:0]  x_q, x_d;
    logic [OP_W-1:0]  y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       x_bits;
    logic [ROW_W-1:0] row;
    logic [P_W-1:0]   row_shifted;

    assign x_bits = x_q[{k_q, 1'b0} +: 2];

    unsigned_mul_8x8_row_pair u_row_pair (
        .x_bits (x_bits),
        .y      (y_q),
        .row    (row)
    );

    assign row_shifted = P_W'(row) << {k_q, 1'b0};

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;

        if (flush) begin
            state_d = IDLE;
            k_d     = '0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_d     = x;
                        y_d     = y;
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    acc_d = acc_q + row_shifted;
                    k_d   = k_q + 2'd1;
                    if (k_q == 2'(ROWS - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // Returning to IDLE here means the next accept is one edge later.
                    if (out_ready) begin
                        state_d = IDLE;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments only; operand latches are reset too so a fresh reset leaves no stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign p         = (state_q == IDLE) ? '0 : acc_q;
    assign op_count  = cnt_q;

endmodule
